// File: rtl/lcd_scan_scheduler_if.sv
// Pixel-source handshake between the LCD scan scheduler (master) and its two sources.
interface lcd_scan_scheduler_if;
    logic        src0_req;
    logic [15:0] src0_data;
    logic        src0_valid;
    logic        src1_req;
    logic [15:0] src1_data;
    logic        src1_valid;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;

    modport master (
        output src0_req, src1_req, pix_x, pix_y,
        input  src0_data, src0_valid, src1_data, src1_valid
    );

    modport slave (
        input  src0_req, src1_req, pix_x, pix_y,
        output src0_data, src0_valid, src1_data, src1_valid
    );
endinterface

// File: rtl/lcd_scan_scheduler.sv
// Scan timing generator and two-source pixel arbiter for an RGB565 LCD panel.
// Start, stop and source changes only take effect on frame boundaries.
module lcd_scan_scheduler #(
    parameter int H_BP  = 182,
    parameter int H_ACT = 800,
    parameter int H_FP  = 210,
    parameter int H_PW  = 1,
    parameter int V_BP  = 0,
    parameter int V_ACT = 480,
    parameter int V_FP  = 45,
    parameter int V_PW  = 5
) (
    input  logic                        PixelClk,
    input  logic                        nRST,
    input  logic                        enable,
    input  logic                        src_sel,
    input  logic                        underflow_clr,
    lcd_scan_scheduler_if.master        src,
    output logic                        frame_start,
    output logic                        busy,
    output logic                        underflow,
    output logic                        LCD_DE,
    output logic                        LCD_HS,
    output logic                        LCD_VS,
    output logic [4:0]                  LCD_R,
    output logic [5:0]                  LCD_G,
    output logic [4:0]                  LCD_B
);
    localparam int H_TOTAL = H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_BP + V_ACT + V_FP;

    localparam logic [10:0] H_LAST_C = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_BP_C   = 11'(H_BP);
    localparam logic [10:0] H_ACT_C  = 11'(H_ACT);
    localparam logic [10:0] H_PW_C   = 11'(H_PW);
    localparam logic [9:0]  V_LAST_C = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_BP_C   = 10'(V_BP);
    localparam logic [9:0]  V_ACT_C  = 10'(V_ACT);
    localparam logic [9:0]  V_PW_C   = 10'(V_PW);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STOP_PEND = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [10:0] h_cnt_r;
    logic [10:0] h_off_s;
    logic [9:0]  v_cnt_r;
    logic [9:0]  v_off_s;
    logic        sel_r;
    logic        busy_s;
    logic        last_clk_s;
    logic        active_s;
    logic        frame_begin_s;
    logic        req0_s;
    logic        req1_s;
    logic        miss_s;
    logic [15:0] pix_s;
    logic        underflow_r;
    logic        de_r;
    logic        hs_r;
    logic        vs_r;
    logic [15:0] rgb_r;

    assign busy_s     = (state_r != ST_IDLE);
    assign last_clk_s = (h_cnt_r == H_LAST_C) && (v_cnt_r == V_LAST_C);

    // Offsets wrap to large values inside the back porch, so one compare checks both bounds.
    assign h_off_s  = h_cnt_r - H_BP_C;
    assign v_off_s  = v_cnt_r - V_BP_C;
    assign active_s = busy_s && (h_off_s < H_ACT_C) && (v_off_s < V_ACT_C);

    assign req0_s = active_s && !sel_r;
    assign req1_s = active_s && sel_r;
    assign miss_s = (req0_s && !src.src0_valid) || (req1_s && !src.src1_valid);

    assign frame_begin_s = ((state_r == ST_IDLE) && enable) ||
                           (busy_s && last_clk_s && (state_nxt_s != ST_IDLE));

    assign src.src0_req = req0_s;
    assign src.src1_req = req1_s;
    assign src.pix_x    = active_s ? h_off_s : 11'd0;
    assign src.pix_y    = active_s ? v_off_s : 10'd0;
    assign frame_start  = busy_s && (h_cnt_r == 11'd0) && (v_cnt_r == 10'd0);
    assign busy         = busy_s;
    assign underflow    = underflow_r;
    assign LCD_DE       = de_r;
    assign LCD_HS       = hs_r;
    assign LCD_VS       = vs_r;
    assign LCD_R        = rgb_r[15:11];
    assign LCD_G        = rgb_r[10:5];
    assign LCD_B        = rgb_r[4:0];

    // Next scan state: a pending stop may be cancelled until the last clock of the frame.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_nxt_s = ST_RUN;
                else        state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!enable) state_nxt_s = ST_STOP_PEND;
                else         state_nxt_s = ST_RUN;
            end
            ST_STOP_PEND: begin
                if (enable)          state_nxt_s = ST_RUN;
                else if (last_clk_s) state_nxt_s = ST_IDLE;
                else                 state_nxt_s = ST_STOP_PEND;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Pixel for the pins: the selected source's data when it is served, black otherwise.
    always_comb begin
        pix_s = 16'h0000;
        if (req0_s && src.src0_valid)      pix_s = src.src0_data;
        else if (req1_s && src.src1_valid) pix_s = src.src1_data;
        else                               pix_s = 16'h0000;
    end

    // Scan state, timing counters and per-frame source selection.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
            h_cnt_r <= 11'd0;
            v_cnt_r <= 10'd0;
            sel_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (frame_begin_s) sel_r <= src_sel;
            if (!busy_s || (state_nxt_s == ST_IDLE)) begin
                h_cnt_r <= 11'd0;
                v_cnt_r <= 10'd0;
            end else if (h_cnt_r == H_LAST_C) begin
                h_cnt_r <= 11'd0;
                v_cnt_r <= (v_cnt_r == V_LAST_C) ? 10'd0 : v_cnt_r + 10'd1;
            end else begin
                h_cnt_r <= h_cnt_r + 11'd1;
            end
        end
    end

    // Panel pins and the sticky underflow flag, one clock behind the counters.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            de_r        <= 1'b0;
            hs_r        <= 1'b1;
            vs_r        <= 1'b1;
            rgb_r       <= 16'h0000;
            underflow_r <= 1'b0;
        end else begin
            de_r  <= active_s;
            hs_r  <= busy_s ? (h_cnt_r >= H_PW_C) : 1'b1;
            vs_r  <= busy_s ? (v_cnt_r >= V_PW_C) : 1'b1;
            rgb_r <= pix_s;
            if (miss_s)             underflow_r <= 1'b1;
            else if (underflow_clr) underflow_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lcd_scan_scheduler.sv
// Self-checking bench for lcd_scan_scheduler on a shrunken timing so whole frames fit in a short run.
module tb_lcd_scan_scheduler;
    localparam int HBP = 3, HACT = 8, HFP = 4, HPW = 2;
    localparam int VBP = 1, VACT = 4, VFP = 2, VPW = 2;
    localparam int HT = HBP + HACT + HFP;
    localparam int VT = VBP + VACT + VFP;
    localparam int FRAME = HT * VT;
    localparam logic [19:0] RST_REG = {1'b0, 1'b1, 1'b1, 16'h0000, 1'b0};

    logic PixelClk = 1'b0;
    logic nRST = 1'b0;
    logic enable = 1'b0;
    logic src_sel = 1'b0;
    logic underflow_clr = 1'b0;
    logic frame_start, busy, underflow;
    logic LCD_DE, LCD_HS, LCD_VS;
    logic [4:0] LCD_R;
    logic [5:0] LCD_G;
    logic [4:0] LCD_B;

    lcd_scan_scheduler_if sif ();

    lcd_scan_scheduler #(
        .H_BP(HBP), .H_ACT(HACT), .H_FP(HFP), .H_PW(HPW),
        .V_BP(VBP), .V_ACT(VACT), .V_FP(VFP), .V_PW(VPW)
    ) dut (
        .PixelClk(PixelClk), .nRST(nRST), .enable(enable), .src_sel(src_sel),
        .underflow_clr(underflow_clr), .src(sif), .frame_start(frame_start),
        .busy(busy), .underflow(underflow), .LCD_DE(LCD_DE), .LCD_HS(LCD_HS),
        .LCD_VS(LCD_VS), .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B)
    );

    always #5 PixelClk = ~PixelClk;

    typedef struct {
        bit en;
        bit sel;
        bit v0;
        bit v1;
        int cycles;
        bit exp_busy;
        bit exp_uf;
    } vec_t;

    vec_t tbl[9];
    logic [19:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    int m_st = 0;
    int m_pos = 0;
    bit m_sel = 1'b0;
    bit m_uf = 1'b0;

    // stimulus controls
    bit d_en = 1'b0, d_sel = 1'b0, d_v0 = 1'b1, d_v1 = 1'b1, d_clr = 1'b0;
    bit drop_on = 1'b0, clr_on_drop = 1'b0;
    int drop_x0 = 0, drop_y = 0, drop_n = 0;

    function automatic logic [15:0] data0(input int x, input int y);
        logic [31:0] xv, yv;
        xv = x;
        yv = y;
        return {yv[4:0], xv[5:0], xv[4:0]};
    endfunction

    function automatic logic [15:0] data1(input int x, input int y);
        logic [31:0] xv, yv;
        xv = x;
        yv = y;
        return {xv[4:0], yv[5:0], yv[4:0]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] got_reg();
        return 32'({LCD_DE, LCD_HS, LCD_VS, LCD_R, LCD_G, LCD_B, underflow});
    endfunction

    function automatic logic [31:0] got_comb();
        return 32'({sif.src0_req, sif.src1_req, sif.pix_x, sif.pix_y, frame_start, busy});
    endfunction

    // One clock: check last edge's pins, drive inputs, check request side, predict next pins.
    task automatic step();
        int h, v, px, py, nxt;
        bit bsy, act, r0, r1, fs, v0, v1, clr, miss, last;
        logic [15:0] d0, d1, rgb;
        logic [19:0] er;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL pins: scoreboard empty at t=%0t", $time);
        end else begin
            er = exp_q.pop_front();
            chk("pins", got_reg(), 32'(er));
        end
        h = m_pos % HT;
        v = m_pos / HT;
        bsy = (m_st != 0);
        act = bsy && h >= HBP && h < HBP + HACT && v >= VBP && v < VBP + VACT;
        px = act ? h - HBP : 0;
        py = act ? v - VBP : 0;
        r0 = act && !m_sel;
        r1 = act && m_sel;
        fs = bsy && (m_pos == 0);
        v0 = d_v0;
        v1 = d_v1;
        clr = d_clr;
        if (drop_on && act && py == drop_y && px >= drop_x0 && px < drop_x0 + drop_n) begin
            v0 = 1'b0;
            v1 = 1'b0;
            if (clr_on_drop) clr = 1'b1;
        end
        d0 = act ? data0(px, py) : 16'($urandom);
        d1 = act ? data1(px, py) : 16'($urandom);
        enable = d_en;
        src_sel = d_sel;
        underflow_clr = clr;
        sif.src0_valid = v0;
        sif.src1_valid = v1;
        sif.src0_data = d0;
        sif.src1_data = d1;
        #1;
        chk("request", got_comb(), 32'({r0, r1, 11'(px), 10'(py), fs, bsy}));
        miss = (r0 && !v0) || (r1 && !v1);
        rgb = (r0 && v0) ? d0 : ((r1 && v1) ? d1 : 16'h0000);
        m_uf = miss ? 1'b1 : (clr ? 1'b0 : m_uf);
        exp_q.push_back({act, bsy ? (h >= HPW) : 1'b1, bsy ? (v >= VPW) : 1'b1, rgb, m_uf});
        last = (m_pos == FRAME - 1);
        case (m_st)
            0: nxt = d_en ? 1 : 0;
            1: nxt = d_en ? 1 : 2;
            default: nxt = d_en ? 1 : (last ? 0 : 2);
        endcase
        if ((m_st == 0 && d_en) || (m_st != 0 && last && nxt != 0)) m_sel = d_sel;
        if (m_st != 0) m_pos = last ? 0 : m_pos + 1;
        m_st = nxt;
        @(negedge PixelClk);
    endtask

    initial begin
        int guard;
        int tgt;
        //             en    sel   v0    v1    cyc  busy  uf
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1,   5, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1,   1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0,  40, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0,  65, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 105, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1,  30, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1,  20, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1,  55, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1,  10, 1'b0, 1'b0};

        sif.src0_data = 16'h0000;
        sif.src1_data = 16'h0000;
        sif.src0_valid = 1'b0;
        sif.src1_valid = 1'b0;
        repeat (3) @(negedge PixelClk);
        chk("reset pins", got_reg(), 32'(RST_REG));
        chk("reset request", got_comb(), 32'd0);
        nRST = 1'b1;
        exp_q.push_back(RST_REG);

        for (int i = 0; i < 9; i++) begin
            d_en = tbl[i].en;
            d_sel = tbl[i].sel;
            d_v0 = tbl[i].v0;
            d_v1 = tbl[i].v1;
            repeat (tbl[i].cycles) step();
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].exp_busy));
            chk($sformatf("row%0d underflow", i), 32'(underflow), 32'(tbl[i].exp_uf));
        end

        // three starved requests on active row 1 from column 2
        d_en = 1'b1; d_sel = 1'b0; d_v0 = 1'b1; d_v1 = 1'b1;
        drop_on = 1'b1; drop_y = 1; drop_x0 = 2; drop_n = 3; clr_on_drop = 1'b0;
        repeat (46) step();
        chk("underflow set", 32'(underflow), 32'd1);
        d_clr = 1'b1;
        step();
        d_clr = 1'b0;
        chk("underflow cleared", 32'(underflow), 32'd0);
        // clear pulse coincides with a new miss: set must win
        drop_y = 2; drop_x0 = 5; drop_n = 1; clr_on_drop = 1'b1;
        repeat (15) step();
        chk("underflow set beats clear", 32'(underflow), 32'd1);
        drop_on = 1'b0;

        // asynchronous reset at active pixel (4,2)
        tgt = (VBP + 2) * HT + HBP + 4;
        guard = 0;
        while (m_pos != tgt && guard < 3 * FRAME) begin
            step();
            guard++;
        end
        chk("reach reset pixel", 32'(m_pos), 32'(tgt));
        d_en = 1'b0;
        enable = 1'b0;
        nRST = 1'b0;
        #1;
        chk("async reset pins", got_reg(), 32'(RST_REG));
        chk("async reset request", got_comb(), 32'd0);
        exp_q.delete();
        m_st = 0; m_pos = 0; m_sel = 1'b0; m_uf = 1'b0;
        @(negedge PixelClk);
        nRST = 1'b1;
        exp_q.push_back(RST_REG);
        repeat (6) step();
        chk("idle after reset", 32'(busy), 32'd0);
        d_en = 1'b1; d_sel = 1'b1;
        repeat (30) step();
        chk("restart busy", 32'(busy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
